// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: instruction field layout, NOP
// encoding, default widths and the fetch-valid FSM state type.
package fetch_unit_pkg;

   localparam int PC_W_DEF    = 16;
   localparam int INSTR_W_DEF = 16;
   localparam int REG_W_DEF   = 3;

   localparam int OPCODE_W = 4;
   localparam int MODE_W   = 3;

   localparam int OPCODE_LSB = 12;
   localparam int MODE_LSB   = 9;
   localparam int RD_LSB     = 6;
   localparam int RS_LSB     = 3;
   localparam int RT_LSB     = 0;

   // All-zero word decodes to a bubble in the controller
   localparam logic [15:0] INSTR_NOP = 16'h0000;

   localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_LW  = 4'h8;
   localparam logic [OPCODE_W-1:0] OP_SW  = 4'h9;
   localparam logic [OPCODE_W-1:0] OP_BEQ = 4'hA;
   localparam logic [OPCODE_W-1:0] OP_JMP = 4'hC;

   typedef enum logic {
      FETCH_BOOT = 1'b0,
      FETCH_RUN  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_gen.sv
// Next-fetch-address mux and the pc_if register (address whose word is
// currently returning on the instruction bus).
module fetch_unit_pc_gen
   import fetch_unit_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            stall,
   output logic [PC_W-1:0] iaddr,
   output logic [PC_W-1:0] pc_if
);

   logic [PC_W-1:0] next_pc;

   always_comb begin
      next_pc = pc_if + PC_W'(1);
      if (br_taken) begin
         next_pc = br_target;
      end else if (stall) begin
         next_pc = pc_if;
      end
   end

   // Memory sees address 0 while reset is held
   assign iaddr = rst ? '0 : next_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_if <= '0;
      end else begin
         pc_if <= next_pc;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register, load-use hazard detection
// and branch flush.
//
// state      | meaning
// FETCH_BOOT | word on IDATA is not meaningful (after reset or redirect)
// FETCH_RUN  | word on IDATA belongs to pc_if
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int PC_W    = PC_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int REG_W   = REG_W_DEF
) (
   input  logic                CLK,
   input  logic                RST,
   output logic [PC_W-1:0]     IADDR,
   input  logic [INSTR_W-1:0]  IDATA,
   input  logic                EX_MEM2REG,
   input  logic [REG_W-1:0]    EX_RD,
   input  logic                BR_TAKEN,
   input  logic [PC_W-1:0]     BR_TARGET,
   output logic [OPCODE_W-1:0] OPCODE,
   output logic [MODE_W-1:0]   MODE,
   output logic [REG_W-1:0]    RD,
   output logic [REG_W-1:0]    RS,
   output logic [REG_W-1:0]    RT,
   output logic [PC_W-1:0]     PC_ID,
   output logic                VALID_ID,
   output logic                STALL
);

   fetch_state_e       state_q;
   fetch_state_e       state_d;
   logic               fetch_valid;
   logic [PC_W-1:0]    pc_if;
   logic [INSTR_W-1:0] instr_id;
   logic [INSTR_W-1:0] instr_view;
   logic               hazard;

   fetch_unit_pc_gen #(.PC_W(PC_W)) u_pc_gen (
      .clk       (CLK),
      .rst       (RST),
      .br_taken  (BR_TAKEN),
      .br_target (BR_TARGET),
      .stall     (STALL),
      .iaddr     (IADDR),
      .pc_if     (pc_if)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= FETCH_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH_BOOT: state_d = FETCH_RUN;
         FETCH_RUN:  if (BR_TAKEN) state_d = FETCH_BOOT;
         default:    state_d = FETCH_BOOT;
      endcase
   end

   assign fetch_valid = (state_q == FETCH_RUN);

   // Invalid slot is presented as NOP so the controller issues a bubble
   assign instr_view = VALID_ID ? instr_id : INSTR_W'(INSTR_NOP);

   assign OPCODE = instr_view[OPCODE_LSB +: OPCODE_W];
   assign MODE   = instr_view[MODE_LSB +: MODE_W];
   assign RD     = instr_view[RD_LSB +: REG_W];
   assign RS     = instr_view[RS_LSB +: REG_W];
   assign RT     = instr_view[RT_LSB +: REG_W];

   // Compared regardless of opcode: a spurious stall only costs a cycle
   assign hazard = VALID_ID & EX_MEM2REG & ((EX_RD == RS) | (EX_RD == RT));
   assign STALL  = hazard & ~BR_TAKEN;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         instr_id <= '0;
         PC_ID    <= '0;
         VALID_ID <= 1'b0;
      end else if (BR_TAKEN) begin
         instr_id <= '0;
         VALID_ID <= 1'b0;
      end else if (!STALL) begin
         instr_id <= IDATA;
         PC_ID    <= pc_if;
         VALID_ID <= fetch_valid;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios followed by random traffic, checked cycle by cycle
// against a behavioural model of the fetch stage.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic [15:0] IADDR;
   logic [15:0] IDATA;
   logic        EX_MEM2REG;
   logic [2:0]  EX_RD;
   logic        BR_TAKEN;
   logic [15:0] BR_TARGET;
   logic [3:0]  OPCODE;
   logic [2:0]  MODE;
   logic [2:0]  RD;
   logic [2:0]  RS;
   logic [2:0]  RT;
   logic [15:0] PC_ID;
   logic        VALID_ID;
   logic        STALL;

   int total = 0;
   int bad   = 0;

   logic [15:0] imem [0:255];

   // Model state: fetch address, whether the returning word is usable,
   // and the contents of the decode slot.
   int m_pc;
   int m_fv;
   int m_vid;
   int m_word;
   int m_pcid;
   int last_stall;

   fetch_unit dut (
      .CLK        (CLK),
      .RST        (RST),
      .IADDR      (IADDR),
      .IDATA      (IDATA),
      .EX_MEM2REG (EX_MEM2REG),
      .EX_RD      (EX_RD),
      .BR_TAKEN   (BR_TAKEN),
      .BR_TARGET  (BR_TARGET),
      .OPCODE     (OPCODE),
      .MODE       (MODE),
      .RD         (RD),
      .RS         (RS),
      .RT         (RT),
      .PC_ID      (PC_ID),
      .VALID_ID   (VALID_ID),
      .STALL      (STALL)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_fv = 0; m_vid = 0; m_word = 0; m_pcid = 0; last_stall = 0;
   endtask

   // One clock: compare at the falling edge, advance the model with the
   // rising edge, then return the word for the address just issued.
   task automatic step();
      int view, ers, ert, eiaddr, br, stl, din;
      @(negedge CLK);
      view = (m_vid != 0) ? m_word : 0;
      ers  = (view / 8) % 8;
      ert  = view % 8;
      br   = BR_TAKEN ? 1 : 0;
      din  = IDATA;
      stl  = (m_vid != 0 && EX_MEM2REG && (EX_RD == ers || EX_RD == ert) && br == 0) ? 1 : 0;
      if (br != 0)       eiaddr = BR_TARGET;
      else if (stl != 0) eiaddr = m_pc;
      else               eiaddr = (m_pc + 1) % 65536;
      chk("iaddr",    IADDR,    eiaddr);
      chk("stall",    STALL,    stl);
      chk("opcode",   OPCODE,   view / 4096);
      chk("mode",     MODE,     (view / 512) % 8);
      chk("rd",       RD,       (view / 64) % 8);
      chk("rs",       RS,       ers);
      chk("rt",       RT,       ert);
      chk("pc_id",    PC_ID,    m_pcid);
      chk("valid_id", VALID_ID, m_vid);
      last_stall = stl;
      @(posedge CLK);
      #1;
      if (br != 0) begin
         m_vid = 0; m_word = 0;
      end else if (stl == 0) begin
         m_word = din; m_pcid = m_pc; m_vid = m_fv;
      end
      m_fv  = (m_fv != 0) ? ((br != 0) ? 0 : 1) : 1;
      m_pc  = eiaddr;
      IDATA = imem[eiaddr % 256];
   endtask

   initial begin
      logic [15:0] add_w;
      add_w = {OP_ADD, 3'd0, 3'd1, 3'd2, 3'd3};
      for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
      for (int i = 0; i < 8; i++) imem[i] = add_w;

      RST = 1'b1; IDATA = 16'hDEAD; EX_MEM2REG = 1'b0; EX_RD = '0;
      BR_TAKEN = 1'b0; BR_TARGET = '0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_iaddr",  IADDR,    0);
      chk("rst_valid",  VALID_ID, 0);
      chk("rst_pc_id",  PC_ID,    0);
      chk("rst_stall",  STALL,    0);
      chk("rst_opcode", OPCODE,   0);
      RST = 1'b0;
      #1;
      chk("boot_iaddr", IADDR, 1);

      step(); chk("seq_iaddr2", IADDR, 2);
      step(); chk("seq_iaddr3", IADDR, 3); chk("seq_valid", VALID_ID, 1);
      step(); chk("seq_iaddr4", IADDR, 4);

      // load-use on RS
      EX_MEM2REG = 1'b1; EX_RD = 3'd2;
      #1 chk("lu_stall", STALL, 1);
      step();
      EX_MEM2REG = 1'b0;
      #1 chk("lu_release", STALL, 0);
      step();
      step();

      // redirect and hazard in the same cycle: redirect wins
      EX_MEM2REG = 1'b1; EX_RD = 3'd2; BR_TAKEN = 1'b1; BR_TARGET = 16'h0040;
      #1;
      chk("br_hz_stall", STALL, 0);
      chk("br_iaddr",    IADDR, 16'h0040);
      step();
      EX_MEM2REG = 1'b0; BR_TAKEN = 1'b0;
      #1 chk("br_bubble1", VALID_ID, 0);
      step();
      chk("br_bubble2", VALID_ID, 0);
      step();
      step();

      // fetch address wraps from the top of memory
      BR_TAKEN = 1'b1; BR_TARGET = 16'hFFFF;
      step();
      BR_TAKEN = 1'b0;
      #1 chk("wrap_iaddr", IADDR, 0);
      step();
      step();

      // reset while a stall is pending
      EX_MEM2REG = 1'b1; EX_RD = 3'd3;
      #1 chk("rs_stall", STALL, 1);
      RST = 1'b1;
      #1;
      model_reset();
      chk("rs_valid", VALID_ID, 0);
      chk("rs_pc_id", PC_ID,    0);
      chk("rs_iaddr", IADDR,    0);
      chk("rs_stall0", STALL,   0);
      EX_MEM2REG = 1'b0; EX_RD = '0;
      @(posedge CLK);
      #1;
      RST = 1'b0; IDATA = 16'hBEEF;
      #1 chk("rs_restart", IADDR, 1);
      step();
      step();
      chk("rs_valid1", VALID_ID, 1);
      chk("rs_pcid1",  PC_ID,    1);

      for (int n = 0; n < 400; n++) begin
         BR_TAKEN   = ($urandom_range(0, 9) == 0);
         BR_TARGET  = 16'($urandom);
         EX_MEM2REG = (last_stall != 0) ? 1'b0 : ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 1) == 0) EX_RD = RS;
         else                           EX_RD = 3'($urandom_range(0, 7));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
